jtag_reg_bank: RTL and testbench
================================

# jtag_reg_bank

Parametrised AXI4-Lite register bank driven by the JTAG-to-AXI master; it replaces the fixed 4-bit data/address capture slave. It exposes NUM_REGS control registers of REG_WIDTH bits to downstream logic such as the DAC modulator. Writes land in shadow registers and are transferred atomically to the outputs on a commit. Per-register update strobes and an ID/status word are provided.

## Interface
- NUM_REGS, 4: number of control registers (1..32).
- REG_WIDTH, 16: width of each register (1..32).
- ADDR_WIDTH, 32: AXI address width.
- RESET_VAL, 0: reset value of every shadow and output register, truncated to REG_WIDTH.
- aclk  in  1  clock; all logic is on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- s_axil_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axil_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- reg_out  out  NUM_REGS*REG_WIDTH  live register values; register i is at [i*REG_WIDTH +: REG_WIDTH].
- reg_update  out  NUM_REGS  one-cycle pulse on bit i when reg_out slice i is loaded.

## Operation
- Word index = addr[IDX_W+1:2], with IDX_W = clog2(NUM_REGS+2). addr[1:0] and bits above the index are ignored, so the map aliases.
- Index 0..NUM_REGS-1: shadow register i (RW). Bits at and above REG_WIDTH are ignored on write and read back as 0.
- Index NUM_REGS: CTRL.
  - bit0 COMMIT: write 1 copies all shadows to reg_out and pulses every reg_update bit. Reads as 0.
  - bit1 AUTO: RW, reset 0. When set, each shadow write also loads that reg_out slice and pulses its reg_update bit.
- Index NUM_REGS+1: ID (RO) = {8'hA5, 8'(NUM_REGS), 8'(REG_WIDTH), 8'h01}. Writes to it return SLVERR and change nothing.
- Any other index: read returns rdata 0 with SLVERR; write returns SLVERR and changes nothing.
- wstrb is applied per byte. A write with wstrb = 0 changes nothing but still returns OKAY and, for a COMMIT write, does not commit.
- Write path:
  - AW and W are accepted independently, in either order or in the same cycle, each into its own holding register.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Once both are held, the write executes and bvalid rises.
  - bvalid holds with stable bresp until bready; the holding registers clear on the B handshake.
- Read path:
  - arready = !rvalid.
  - On the AR handshake, rdata/rresp are registered and rvalid rises the next cycle.
  - rvalid holds with stable rdata until rready.
- Reset mid-transaction: all handshake outputs deassert immediately and held AW/W are discarded. Masters must restart.

## Timing
- Reset values: awready=1, wready=1, arready=1; bvalid=0, rvalid=0; bresp=0, rresp=0, rdata=0; reg_out=RESET_VAL in every slice; reg_update=0; AUTO=0.
- Write: last of AW/W handshakes at cycle T, then shadow, reg_out, reg_update and bvalid all update at T+1.
- Minimum write spacing is 2 cycles with bready held high.
- Read: AR handshake at T, then rvalid at T+1. Back-to-back reads are possible every 2 cycles with rready held high.
- A read whose AR handshake is in the same cycle a write executes returns the pre-write value.
- reg_update is exactly one cycle wide. Consecutive commits give consecutive pulses.

## Configuration
- JTAG_REG_BANK_SHADOW_EN defined: shadow/commit behaviour as above.
- Not defined:
  - No shadow registers; writes load reg_out directly and pulse the matching reg_update bit at T+1.
  - CTRL reads 0 and accepts writes with OKAY but has no effect.
  - Register reads return reg_out.

## Test plan
- Reset with NUM_REGS=4, REG_WIDTH=16, RESET_VAL=16'h0800 -> all reg_out slices are 0x0800, reg_update=0, and an ID read returns 0xA5041001.
- Write 0x1234ABCD to index 1 -> read returns 0x0000ABCD and reg_out is unchanged. Write CTRL=1 -> slice 1 = 0xABCD and reg_update=4'b1111 for one cycle.
- W presented 3 cycles before AW, then AW with bready held low for 5 cycles -> bvalid stays high and stable until bready, with no second write accepted meanwhile.
- Set CTRL.AUTO=1, then write 0x55 with wstrb=4'b0001 to index 2 over prior 0xFFFF -> slice 2 = 0xFF55 at T+1 and reg_update=4'b0100.
- Read index 7 and write index 7 -> rdata=0 with rresp=2'b10, and bresp=2'b10. Write to ID -> SLVERR and the ID is unchanged.
- Drop arst_n while bvalid is pending -> bvalid=0 and all outputs return to reset values immediately. After release, a fresh write completes normally.

Source files
------------

// File: rtl/jtag_reg_bank.sv
// AXI4-Lite register bank with per-register update strobes and an ID word.
// Define JTAG_REG_BANK_SHADOW_EN for shadow registers committed via CTRL; otherwise writes load reg_out directly.
module jtag_reg_bank #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned REG_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic                          aclk,
  input  logic                          arst_n,
  input  logic [ADDR_WIDTH-1:0]         s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [31:0]                   s_axil_wdata,
  input  logic [3:0]                    s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]         s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [31:0]                   s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]           reg_update
);

  localparam int unsigned          IDX_W       = $clog2(NUM_REGS + 2);
  localparam logic [REG_WIDTH-1:0] RST_V       = REG_WIDTH'(RESET_VAL);
  localparam logic [IDX_W-1:0]     CTRL_IDX    = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0]     ID_IDX      = IDX_W'(NUM_REGS + 1);
  localparam logic [31:0]          ID_WORD     = {8'hA5, 8'(NUM_REGS), 8'(REG_WIDTH), 8'h01};
  localparam logic [1:0]           RESP_OKAY   = 2'b00;
  localparam logic [1:0]           RESP_SLVERR = 2'b10;

  logic                          aw_held, w_held, bvalid_q, rvalid_q;
  logic [IDX_W-1:0]              aw_idx_q, wr_idx, rd_idx;
  logic [31:0]                   w_data_q, wr_data, rdata_q, rd_data;
  logic [3:0]                    w_strb_q, wr_strb;
  logic [1:0]                    bresp_q, rresp_q, rd_resp;
  logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs, exec;
  logic [NUM_REGS*REG_WIDTH-1:0] out_q, rd_src;
  logic [NUM_REGS-1:0]           upd_q;
  logic                          unused_addr;
`ifdef JTAG_REG_BANK_SHADOW_EN
  logic [NUM_REGS*REG_WIDTH-1:0] shadow_q;
  logic                          auto_q;
`endif

  function automatic logic [REG_WIDTH-1:0] merge(input logic [REG_WIDTH-1:0] old,
                                                 input logic [31:0] data,
                                                 input logic [3:0] strb);
    logic [31:0] w;
    w = 32'(old);
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    return w[REG_WIDTH-1:0];
  endfunction

  assign s_axil_awready = !aw_held && !bvalid_q;
  assign s_axil_wready  = !w_held && !bvalid_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_out        = out_q;
  assign reg_update     = upd_q;
  assign unused_addr    = ^{s_axil_awaddr, s_axil_araddr};

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign b_hs  = bvalid_q && s_axil_bready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;
  assign r_hs  = rvalid_q && s_axil_rready;

  // A write executes on the edge that completes the AW/W pair, using the live bus for whichever half arrives last.
  always_comb begin
    wr_idx  = aw_held ? aw_idx_q : s_axil_awaddr[IDX_W+1:2];
    wr_data = w_held ? w_data_q : s_axil_wdata;
    wr_strb = w_held ? w_strb_q : s_axil_wstrb;
  end
  assign exec = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid_q;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_axil_awaddr[IDX_W+1:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (exec) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_idx <= CTRL_IDX) ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      out_q    <= {NUM_REGS{RST_V}};
      upd_q    <= '0;
`ifdef JTAG_REG_BANK_SHADOW_EN
      shadow_q <= {NUM_REGS{RST_V}};
      auto_q   <= 1'b0;
`endif
    end else begin
      upd_q <= '0;
      if (exec && (|wr_strb)) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (wr_idx == IDX_W'(i)) begin
`ifdef JTAG_REG_BANK_SHADOW_EN
            shadow_q[i*REG_WIDTH +: REG_WIDTH] <= merge(shadow_q[i*REG_WIDTH +: REG_WIDTH], wr_data, wr_strb);
            if (auto_q) begin
              out_q[i*REG_WIDTH +: REG_WIDTH] <= merge(shadow_q[i*REG_WIDTH +: REG_WIDTH], wr_data, wr_strb);
              upd_q[i] <= 1'b1;
            end
`else
            out_q[i*REG_WIDTH +: REG_WIDTH] <= merge(out_q[i*REG_WIDTH +: REG_WIDTH], wr_data, wr_strb);
            upd_q[i] <= 1'b1;
`endif
          end
        end
`ifdef JTAG_REG_BANK_SHADOW_EN
        if (wr_idx == CTRL_IDX && wr_strb[0]) begin
          auto_q <= wr_data[1];
          if (wr_data[0]) begin
            out_q <= shadow_q;
            upd_q <= '1;
          end
        end
`endif
      end
    end
  end

`ifdef JTAG_REG_BANK_SHADOW_EN
  assign rd_src = shadow_q;
`else
  assign rd_src = out_q;
`endif

  always_comb begin
    rd_idx  = s_axil_araddr[IDX_W+1:2];
    rd_data = '0;
    rd_resp = RESP_OKAY;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDX_W'(i)) rd_data = 32'(rd_src[i*REG_WIDTH +: REG_WIDTH]);
    if (rd_idx == CTRL_IDX) begin
`ifdef JTAG_REG_BANK_SHADOW_EN
      rd_data = {30'b0, auto_q, 1'b0};
`else
      rd_data = '0;
`endif
    end else if (rd_idx == ID_IDX) begin
      rd_data = ID_WORD;
    end else if (rd_idx > ID_IDX) begin
      rd_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_reg_bank.sv
// Randomised AXI4-Lite bench for jtag_reg_bank against a register-level reference model.
module tb_jtag_reg_bank;
  localparam int unsigned NR = 4;
`ifdef JTAG_REG_BANK_SHADOW_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  logic        clk, arst_n;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic [63:0] reg_out;
  logic [3:0]  reg_update;

  int unsigned checks = 0;
  int unsigned errors = 0;

  jtag_reg_bank #(
    .NUM_REGS(4), .REG_WIDTH(16), .ADDR_WIDTH(32), .RESET_VAL(32'h0800)
  ) dut (
    .aclk(clk), .arst_n(arst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .reg_out(reg_out), .reg_update(reg_update)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register contents plus the pending-transaction view of each channel.
  logic [15:0] m_shadow [4];
  logic [15:0] m_out [4];
  logic        m_auto;
  logic [3:0]  m_upd;
  logic        m_aw_held, m_w_held, m_bvalid, m_rvalid;
  logic [2:0]  m_aw_idx;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 16'h0800;
      m_out[i]    = 16'h0800;
    end
    m_auto = 1'b0; m_upd = '0;
    m_aw_held = 1'b0; m_w_held = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
    m_aw_idx = '0; m_wdata = '0; m_wstrb = '0;
    m_rdata = '0; m_bresp = 2'b00; m_rresp = 2'b00;
  endtask

  task automatic model_read(input logic [2:0] idx, output logic [31:0] d, output logic [1:0] r);
    d = 32'h0;
    r = 2'b00;
    if (idx < 3'd4)      d = {16'h0, SHADOW_EN ? m_shadow[idx[1:0]] : m_out[idx[1:0]]};
    else if (idx == 3'd4) d = (SHADOW_EN && m_auto) ? 32'h2 : 32'h0;
    else if (idx == 3'd5) d = 32'hA504_1001;
    else                  r = 2'b10;
  endtask

  task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [15:0] v;
    resp = (idx > 3'd4) ? 2'b10 : 2'b00;
    if (idx < 3'd4 && s != 4'h0) begin
      v = SHADOW_EN ? m_shadow[idx[1:0]] : m_out[idx[1:0]];
      if (s[0]) v[7:0]  = d[7:0];
      if (s[1]) v[15:8] = d[15:8];
      if (SHADOW_EN) m_shadow[idx[1:0]] = v;
      if (!SHADOW_EN || m_auto) begin
        m_out[idx[1:0]] = v;
        m_upd[idx[1:0]] = 1'b1;
      end
    end else if (idx == 3'd4 && SHADOW_EN && s[0]) begin
      if (d[0]) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
        m_upd = 4'hF;
      end
      m_auto = d[1];
    end
  endtask

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      model_reset();
    end else begin
      logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
      aw_fire = s_axil_awvalid && !m_aw_held && !m_bvalid;
      w_fire  = s_axil_wvalid && !m_w_held && !m_bvalid;
      b_fire  = m_bvalid && s_axil_bready;
      ar_fire = s_axil_arvalid && !m_rvalid;
      r_fire  = m_rvalid && s_axil_rready;
      m_upd = '0;
      if (ar_fire) begin
        model_read(s_axil_araddr[4:2], m_rdata, m_rresp);
        m_rvalid = 1'b1;
      end else if (r_fire) begin
        m_rvalid = 1'b0;
      end
      if (b_fire) begin
        m_bvalid = 1'b0; m_aw_held = 1'b0; m_w_held = 1'b0;
      end
      if (aw_fire) begin
        m_aw_held = 1'b1; m_aw_idx = s_axil_awaddr[4:2];
      end
      if (w_fire) begin
        m_w_held = 1'b1; m_wdata = s_axil_wdata; m_wstrb = s_axil_wstrb;
      end
      if (m_aw_held && m_w_held && !m_bvalid) begin
        model_write(m_aw_idx, m_wdata, m_wstrb, m_bresp);
        m_bvalid = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    #10;
    forever begin
      @(negedge clk);
      chk("awready", 64'(s_axil_awready), 64'(!m_aw_held && !m_bvalid));
      chk("wready", 64'(s_axil_wready), 64'(!m_w_held && !m_bvalid));
      chk("arready", 64'(s_axil_arready), 64'(!m_rvalid));
      chk("bvalid", 64'(s_axil_bvalid), 64'(m_bvalid));
      if (m_bvalid) chk("bresp", 64'(s_axil_bresp), 64'(m_bresp));
      chk("rvalid", 64'(s_axil_rvalid), 64'(m_rvalid));
      chk("rdata", 64'(s_axil_rdata), 64'(m_rdata));
      chk("rresp", 64'(s_axil_rresp), 64'(m_rresp));
      chk("reg_out", reg_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
      chk("reg_update", 64'(reg_update), 64'(m_upd));
    end
  end

  // Called right after a falling edge; returns bresp and the reg_update seen when bvalid first rises.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int unsigned aw_dly, input int unsigned w_dly, input int unsigned b_dly,
                          output logic [1:0] resp, output logic [3:0] upd);
    bit aw_done = 0, w_done = 0, b_done = 0, b_seen = 0;
    int unsigned cyc = 0, bcyc = 0;
    resp = 2'b11;
    upd  = 4'hX;
    s_axil_awaddr = addr;
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    while (!b_done && cyc < 100) begin
      s_axil_awvalid = !aw_done && cyc >= aw_dly;
      s_axil_wvalid  = !w_done && cyc >= w_dly;
      if (s_axil_bvalid && !b_seen) begin
        b_seen = 1;
        upd = reg_update;
      end
      s_axil_bready = b_seen && bcyc >= b_dly;
      if (s_axil_awvalid && s_axil_awready) aw_done = 1;
      if (s_axil_wvalid && s_axil_wready) w_done = 1;
      if (s_axil_bready && s_axil_bvalid) begin
        b_done = 1;
        resp = s_axil_bresp;
      end
      if (b_seen) bcyc++;
      @(negedge clk);
      cyc++;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b0;
    if (!b_done) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got no B handshake, expected one within 100 cycles at %0t", $time);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int unsigned ar_dly, input int unsigned r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, r_seen = 0;
    int unsigned cyc = 0, rcyc = 0;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    s_axil_araddr = addr;
    while (!r_done && cyc < 100) begin
      s_axil_arvalid = !ar_done && cyc >= ar_dly;
      if (s_axil_rvalid) r_seen = 1;
      s_axil_rready = r_seen && rcyc >= r_dly;
      if (s_axil_arvalid && s_axil_arready) ar_done = 1;
      if (s_axil_rready && s_axil_rvalid) begin
        r_done = 1;
        data = s_axil_rdata;
        resp = s_axil_rresp;
      end
      if (r_seen) rcyc++;
      @(negedge clk);
      cyc++;
    end
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b0;
    if (!r_done) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no R handshake, expected one within 100 cycles at %0t", $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp, rr, resp2, rr2;
    logic [3:0]  upd, upd2;
    logic [31:0] rd, rd2;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    chk("reset_reg_out", reg_out, {4{16'h0800}});
    chk("reset_reg_update", 64'(reg_update), 64'h0);
    chk("reset_rdata", 64'(s_axil_rdata), 64'h0);

    do_read(32'h14, 0, 0, rd, rr);
    chk("id_read", 64'(rd), 64'hA504_1001);
    chk("id_rresp", 64'(rr), 64'h0);

    do_write(32'h4, 32'h1234_ABCD, 4'hF, 0, 0, 0, resp, upd);
    chk("wr1_bresp", 64'(resp), 64'h0);
    chk("wr1_update", 64'(upd), SHADOW_EN ? 64'h0 : 64'h2);
    chk("wr1_slice1", 64'(reg_out[31:16]), SHADOW_EN ? 64'h0800 : 64'hABCD);
    do_read(32'h4, 0, 0, rd, rr);
    chk("wr1_readback", 64'(rd), 64'h0000_ABCD);

    do_write(32'h10, 32'h1, 4'hF, 0, 0, 0, resp, upd);
    chk("commit_update", 64'(upd), SHADOW_EN ? 64'hF : 64'h0);
    chk("commit_slice1", 64'(reg_out[31:16]), 64'hABCD);
    chk("commit_slice0", 64'(reg_out[15:0]), 64'h0800);

    do_write(32'hC, 32'h0000_3C3C, 4'hF, 3, 0, 5, resp, upd);
    chk("w_first_bresp", 64'(resp), 64'h0);
    do_read(32'hC, 0, 0, rd, rr);
    chk("w_first_readback", 64'(rd), 64'h3C3C);

    do_write(32'h10, 32'h2, 4'hF, 0, 0, 0, resp, upd);
    do_write(32'h8, 32'h0000_FFFF, 4'hF, 0, 0, 0, resp, upd);
    do_write(32'h8, 32'h0000_0055, 4'b0001, 0, 0, 0, resp, upd);
    chk("auto_update", 64'(upd), 64'h4);
    chk("auto_slice2", 64'(reg_out[47:32]), 64'hFF55);

    do_read(32'h1C, 0, 0, rd, rr);
    chk("bad_read_data", 64'(rd), 64'h0);
    chk("bad_read_rresp", 64'(rr), 64'h2);
    do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, upd);
    chk("bad_write_bresp", 64'(resp), 64'h2);
    do_write(32'h14, 32'h0, 4'hF, 0, 0, 0, resp, upd);
    chk("id_write_bresp", 64'(resp), 64'h2);
    do_read(32'hFFFF_FF16, 0, 0, rd, rr);
    chk("id_after_write", 64'(rd), 64'hA504_1001);

    do_write(32'h10, 32'h0, 4'hF, 0, 0, 0, resp, upd);
    do_write(32'h0, 32'h0000_7777, 4'hF, 0, 0, 0, resp, upd);
    do_write(32'h10, 32'h1, 4'h0, 0, 0, 0, resp, upd);
    chk("nostrb_commit_bresp", 64'(resp), 64'h0);
    chk("nostrb_commit_update", 64'(upd), 64'h0);
    chk("nostrb_commit_slice0", 64'(reg_out[15:0]), SHADOW_EN ? 64'h0800 : 64'h7777);

    s_axil_awaddr = 32'h0; s_axil_wdata = 32'h0000_4444; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("pending_bvalid", 64'(s_axil_bvalid), 64'h1);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_bvalid", 64'(s_axil_bvalid), 64'h0);
    chk("rst_awready", 64'(s_axil_awready), 64'h1);
    chk("rst_wready", 64'(s_axil_wready), 64'h1);
    chk("rst_reg_out", reg_out, {4{16'h0800}});
    chk("rst_reg_update", 64'(reg_update), 64'h0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    do_write(32'h4, 32'h0000_9999, 4'hF, 1, 0, 0, resp, upd);
    chk("post_rst_bresp", 64'(resp), 64'h0);
    do_read(32'h4, 0, 0, rd, rr);
    chk("post_rst_readback", 64'(rd), 64'h9999);

    for (int unsigned n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [31:0] waddr, raddr, wdat;
      logic [3:0]  wstb;
      kind  = $urandom_range(0, 9);
      waddr = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
      raddr = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
      wdat  = $urandom;
      wstb  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      if (kind < 4) begin
        do_write(waddr, wdat, wstb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 resp, upd);
      end else if (kind < 7) begin
        do_read(raddr, $urandom_range(0, 2), $urandom_range(0, 3), rd, rr);
      end else begin
        fork
          do_write(waddr, wdat, wstb, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   resp2, upd2);
          do_read(raddr, $urandom_range(0, 2), $urandom_range(0, 2), rd2, rr2);
        join
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
